// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises fetch (read-only) and LSU (read/write) requests onto a single-ported byte-addressed data RAM
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   if_req_* / if_resp_*     fetch request/response; always a 32-bit zero-extended read (WU)
//   lsu_req_* / lsu_resp_*   LSU request/response; loads and stores of any width code
//   ram_*_o                  RAM address, direction (0 = write), write data, width code
//   ram_rdata_i              RAM registered read data (valid the cycle after a read issue)
//   ram_unalign_i            RAM combinational misalignment flag for the current drive
module ram_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int RAM_SIZE     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [RAM_SIZE-1:0]   if_req_addr,
    output logic                  if_resp_valid,
    input  logic                  if_resp_ready,
    output logic [DATA_WIDTH-1:0] if_resp_data,
    output logic                  if_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_we,
    input  logic [2:0]            lsu_req_wid,
    input  logic [RAM_SIZE-1:0]   lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_data,
    output logic                  lsu_resp_err,
    output logic [RAM_SIZE-1:0]   ram_addr_o,
    output logic                  ram_ewr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [2:0]            ram_wid_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    input  logic                  ram_unalign_i
);
    localparam int         SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [2:0] WID_WU   = 3'b110;
    localparam logic [2:0] WID_NONE = 3'b111;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;  // 1 = fetch owns the current transaction
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  if_win, lsu_win, rd_ok, wr_ok, rsp;
    logic [2:0]            g_wid;
    logic [RAM_SIZE-1:0]   g_addr;

    // Natural alignment by access size; B/BU and the illegal 111 code never report misalignment here.
    function automatic logic misal(input logic [2:0] wid, input logic [2:0] a);
        return (wid[1:0] == 2'b01 && a[0]) ||
               (wid[1:0] == 2'b10 && a[1:0] != 2'b00) ||
               (wid == 3'b011 && a != 3'b000);
    endfunction

    // Arbitration and issue decode; gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        if_win  = rst_n && state_q == IDLE && if_req_valid &&
                  (!lsu_req_valid || starve_q == SW'(STARVE_LIMIT));
        lsu_win = rst_n && state_q == IDLE && lsu_req_valid && !if_win;
        g_wid   = if_win ? WID_WU : lsu_req_wid;
        g_addr  = if_win ? if_req_addr : lsu_req_addr;
        rd_ok   = (if_win || (lsu_win && !lsu_req_we)) && g_wid != WID_NONE && !misal(g_wid, g_addr[2:0]);
        // Stores only take the sign-extending codes; the RAM suppresses misaligned ones itself.
        wr_ok   = lsu_win && lsu_req_we && !lsu_req_wid[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        data_d   = data_q;
        err_d    = err_q;
        starve_d = if_win ? '0 :
                   (if_req_valid && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
        case (state_q)
            IDLE: begin
                if (if_win || lsu_win) begin
                    owner_d = if_win;
                    data_d  = '0;
                    err_d   = rd_ok ? 1'b0 : wr_ok ? ram_unalign_i : 1'b1;
                    state_d = rd_ok ? RD_WAIT : RESP;
                end
            end
            RD_WAIT: begin
                data_d  = ram_rdata_i;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP:    state_d = (owner_q ? if_resp_ready : lsu_resp_ready) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp            = state_q == RESP;
        if_req_ready   = if_win;
        lsu_req_ready  = lsu_win;
        if_resp_valid  = rsp && owner_q;
        lsu_resp_valid = rsp && !owner_q;
        if_resp_data   = if_resp_valid ? data_q : '0;
        lsu_resp_data  = lsu_resp_valid ? data_q : '0;
        if_resp_err    = if_resp_valid && err_q;
        lsu_resp_err   = lsu_resp_valid && err_q;
        ram_ewr_o      = !wr_ok;
        ram_wid_o      = (rd_ok || wr_ok) ? g_wid : WID_NONE;
        ram_addr_o     = (rd_ok || wr_ok) ? g_addr : '0;
        ram_wdata_o    = wr_ok ? lsu_req_wdata : '0;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench for ram_arbiter with a behavioural RAM and reference model
module tb_ram_arbiter;
    localparam int DW = 64, AW = 16, LIM = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          if_req_valid = 0, if_req_ready, if_resp_valid, if_resp_ready = 1, if_resp_err;
    logic [AW-1:0] if_req_addr = '0;
    logic [DW-1:0] if_resp_data;
    logic          lsu_req_valid = 0, lsu_req_ready, lsu_req_we = 0, lsu_resp_valid, lsu_resp_ready = 1, lsu_resp_err;
    logic [2:0]    lsu_req_wid = '0;
    logic [AW-1:0] lsu_req_addr = '0;
    logic [DW-1:0] lsu_req_wdata = '0, lsu_resp_data;
    logic [AW-1:0] ram_addr_o;
    logic          ram_ewr_o, ram_unalign;
    logic [DW-1:0] ram_wdata_o, ram_rdata = '0;
    logic [2:0]    ram_wid_o;

    ram_arbiter #(.DATA_WIDTH(DW), .RAM_SIZE(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
        .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
        .lsu_req_wid(lsu_req_wid), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .ram_addr_o(ram_addr_o), .ram_ewr_o(ram_ewr_o), .ram_wdata_o(ram_wdata_o), .ram_wid_o(ram_wid_o),
        .ram_rdata_i(ram_rdata), .ram_unalign_i(ram_unalign)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          gcyc;
        int          lat;
    } exp_t;

    exp_t        q_if[$], q_lsu[$];
    logic [7:0]  mem[65536];
    logic [7:0]  sh[65536];
    int          cyc = 0, n_chk = 0, n_fail = 0, wait_cnt = 0;
    bit          busy = 0;
    logic        if_prev = 0, lsu_prev = 0;
    logic [64:0] if_held = '0, lsu_held = '0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37) ^ (i >> 7) ^ 8'h5A);
    endfunction

    function automatic int nbytes(input logic [2:0] w);
        return 1 << w[1:0];
    endfunction

    function automatic logic [63:0] ext(input logic [63:0] raw, input logic [2:0] w);
        int          nb;
        logic [63:0] m, v;
        nb = 8 * nbytes(w);
        m  = (nb == 64) ? '1 : (64'd1 << nb) - 64'd1;
        v  = raw & m;
        if (w < 3'd4 && nb < 64 && raw[nb-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [63:0] ram_raw(input logic [15:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i+:8] = mem[a + 16'(i)];
        return r;
    endfunction

    function automatic logic [63:0] sh_raw(input logic [15:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i+:8] = sh[a + 16'(i)];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered reads, byte-lane writes, misaligned writes suppressed.
    always_comb ram_unalign = ram_wid_o != 3'd7 && (int'(ram_addr_o) % nbytes(ram_wid_o)) != 0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (!ram_ewr_o && !ram_unalign && ram_wid_o < 3'd4)
                for (int i = 0; i < nbytes(ram_wid_o); i++) mem[ram_addr_o + 16'(i)] <= ram_wdata_o[8*i+:8];
            else if (ram_ewr_o && ram_wid_o != 3'd7)
                ram_rdata <= ext(ram_raw(ram_addr_o), ram_wid_o);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the response of a granted request follows from its width code, address and the shadow memory.
    task automatic issue(input bit f);
        logic [2:0]  w;
        logic [15:0] a;
        exp_t        e;
        int          n;
        bit          rd, wr;
        w = f ? 3'd6 : lsu_req_wid;
        a = f ? if_req_addr : lsu_req_addr;
        n = nbytes(w);
        e.gcyc = cyc; e.data = '0; e.err = 1'b1; e.lat = 1; rd = 0; wr = 0;
        if (f || !lsu_req_we) begin
            if (w != 3'd7 && int'(a) % n == 0) begin
                rd = 1; e.err = 1'b0; e.lat = 2; e.data = ext(sh_raw(a), w);
            end
        end else if (w < 3'd4) begin
            wr = 1;
            e.err = (int'(a) % n) != 0;
            if (!e.err) for (int i = 0; i < n; i++) sh[a + 16'(i)] = lsu_req_wdata[8*i+:8];
        end
        if (rd) chk("ram read", {ram_ewr_o, ram_wid_o, ram_addr_o}, {1'b1, w, a});
        else if (wr) chk("ram write", {ram_ewr_o, ram_wid_o, ram_addr_o, ram_wdata_o}, {1'b0, w, a, lsu_req_wdata});
        else chk("ram idle on reject", {ram_ewr_o, ram_wid_o, ram_addr_o, ram_wdata_o}, {1'b1, 3'd7, 16'h0, 64'h0});
        if (f) q_if.push_back(e); else q_lsu.push_back(e);
    endtask

    task automatic req_mon();
        bit exp_if, exp_lsu, gi, gl;
        exp_if  = !busy && if_req_valid && (!lsu_req_valid || wait_cnt == LIM);
        exp_lsu = !busy && lsu_req_valid && !exp_if;
        chk("grant", {if_req_ready, lsu_req_ready}, {exp_if, exp_lsu});
        gi = if_req_valid && if_req_ready;
        gl = lsu_req_valid && lsu_req_ready;
        if (gi) issue(1);
        else if (gl) issue(0);
        else chk("ram idle", {ram_ewr_o, ram_wid_o, ram_addr_o, ram_wdata_o}, {1'b1, 3'd7, 16'h0, 64'h0});
        if (gi) wait_cnt = 0;
        else if (if_req_valid && wait_cnt < LIM) wait_cnt++;
        if (gi || gl) busy = 1;
        else if ((if_resp_valid && if_resp_ready) || (lsu_resp_valid && lsu_resp_ready)) busy = 0;
    endtask

    task automatic rsp_port(input string nm, input logic v, input logic r, input logic [63:0] d, input logic e,
                            input bit have, input exp_t fr, inout logic prev, inout logic [64:0] held, output bit pop);
        pop = 0;
        if (v && !prev) begin
            chk({nm, " expected response"}, have, 1);
            if (have) begin
                chk({nm, " latency"}, cyc - fr.gcyc, fr.lat);
                chk({nm, " data"}, d, fr.data);
                chk({nm, " err"}, e, fr.err);
            end
        end else if (v) chk({nm, " hold"}, {e, d}, held);
        if (v) held = {e, d};
        if (v && r) pop = have;
        if (have && !v && cyc - fr.gcyc > 60) begin
            chk({nm, " timeout"}, cyc - fr.gcyc, fr.lat);
            pop = 1;
        end
        prev = v && !r;
    endtask

    // Monitor: requests push expectations, responses pop and compare.
    initial begin
        exp_t fr;
        bit   p;
        for (int i = 0; i < 65536; i++) sh[i] = pat(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset outputs", {if_req_ready, lsu_req_ready, if_resp_valid, lsu_resp_valid, if_resp_err, lsu_resp_err}, 0);
                chk("reset data", if_resp_data | lsu_resp_data, 0);
                wait_cnt = 0; busy = 0; if_prev = 0; lsu_prev = 0;
                q_if.delete(); q_lsu.delete();
            end else begin
                req_mon();
                fr = '{default: 0};
                if (q_if.size() > 0) fr = q_if[0];
                rsp_port("if", if_resp_valid, if_resp_ready, if_resp_data, if_resp_err, q_if.size() > 0, fr, if_prev, if_held, p);
                if (p) void'(q_if.pop_front());
                fr = '{default: 0};
                if (q_lsu.size() > 0) fr = q_lsu[0];
                rsp_port("lsu", lsu_resp_valid, lsu_resp_ready, lsu_resp_data, lsu_resp_err, q_lsu.size() > 0, fr, lsu_prev, lsu_held, p);
                if (p) void'(q_lsu.pop_front());
            end
        end
    end

    task automatic wait_lsu_grant();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lsu_req_ready) break;
        end
    endtask

    task automatic wait_if_grant();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (if_req_ready) break;
        end
    endtask

    task automatic lsu_go(input logic we, input logic [2:0] w, input logic [15:0] a, input logic [63:0] d);
        lsu_req_we = we; lsu_req_wid = w; lsu_req_addr = a; lsu_req_wdata = d; lsu_req_valid = 1;
        wait_lsu_grant();
        @(posedge clk); #1 lsu_req_valid = 0;
    endtask

    task automatic if_go(input logic [15:0] a);
        if_req_addr = a; if_req_valid = 1;
        wait_if_grant();
        @(posedge clk); #1 if_req_valid = 0;
    endtask

    task automatic rand_lsu();
        lsu_req_we    = 1'($urandom % 2);
        lsu_req_wid   = 3'($urandom % 8);
        lsu_req_addr  = 16'($urandom_range(0, 63));
        lsu_req_wdata = {$urandom, $urandom};
    endtask

    task automatic rst_during(input int k);
        lsu_resp_ready = 0;
        lsu_req_we = 0; lsu_req_wid = 3'd3; lsu_req_addr = 16'h10; lsu_req_valid = 1;
        wait_lsu_grant();
        repeat (k) @(posedge clk);
        #1 rst_n = 0; lsu_req_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; lsu_resp_ready = 1;
    endtask

    initial begin
        bit lg, ig;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        lsu_go(1, 3'd3, 16'h10, 64'h1122334455667788);
        lsu_go(0, 3'd3, 16'h10, 0);
        lsu_go(1, 3'd0, 16'h21, 64'h80);
        lsu_go(0, 3'd0, 16'h21, 0);
        lsu_go(0, 3'd4, 16'h21, 0);
        lsu_go(0, 3'd2, 16'h22, 0);
        lsu_go(1, 3'd1, 16'h33, 64'hBEEF);
        lsu_go(0, 3'd1, 16'h32, 0);
        lsu_go(0, 3'd3, 16'h30, 0);
        lsu_go(0, 3'd7, 16'h40, 0);
        lsu_go(1, 3'd6, 16'h40, 64'h5);
        lsu_go(1, 3'd7, 16'h40, 64'h5);
        if_go(16'h10);
        if_go(16'h12);
        repeat (3) @(posedge clk);
        #1 if_resp_ready = 0; if_req_addr = 16'h14; if_req_valid = 1;
        wait_if_grant();
        @(posedge clk); #1 if_req_valid = 0;
        lsu_req_we = 0; lsu_req_wid = 3'd3; lsu_req_addr = 16'h10; lsu_req_valid = 1;
        repeat (8) @(posedge clk);
        #1 if_resp_ready = 1;
        wait_lsu_grant();
        @(posedge clk); #1 lsu_req_valid = 0;
        repeat (3) @(posedge clk);
        #1 rand_lsu(); if_req_addr = 16'($urandom_range(0, 63)); lsu_req_valid = 1; if_req_valid = 1;
        repeat (300) begin
            @(negedge clk);
            lg = lsu_req_ready; ig = if_req_ready;
            @(posedge clk); #1;
            if (lg) rand_lsu();
            if (ig) if_req_addr = 16'($urandom_range(0, 63));
        end
        lsu_req_valid = 0; if_req_valid = 0;
        repeat (1500) begin
            @(posedge clk); #1;
            lsu_req_valid  = ($urandom % 3) != 0;
            rand_lsu();
            if_req_valid   = 1'($urandom % 2);
            if_req_addr    = 16'($urandom_range(0, 63));
            lsu_resp_ready = ($urandom % 4) != 0;
            if_resp_ready  = ($urandom % 4) != 0;
        end
        lsu_req_valid = 0; if_req_valid = 0; lsu_resp_ready = 1; if_resp_ready = 1;
        repeat (5) @(posedge clk);
        #1 rst_during(1);
        lsu_go(0, 3'd3, 16'h10, 0);
        repeat (3) @(posedge clk);
        #1 rst_during(2);
        lsu_go(1, 3'd2, 16'h18, 64'hCAFEF00D);
        lsu_go(0, 3'd2, 16'h18, 0);
        if_go(16'h18);
        repeat (6) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
